// File: rtl/door_access_sequencer.sv
// Round-robin access sequencer in front of the single-door motor controller.
// It grants one request source at a time and sends a one-cycle ACTIVATE pulse.
// It watches the motor outputs and limit switches, closes the door again after
// a hold time, and latches a fault (with motor inhibit) on a motor-run timeout
// or on an obstacle while closing.
module door_access_sequencer #(
    parameter int NREQ           = 3,
    parameter int AUTO_CLOSE_CYC = 1000,
    parameter int TIMEOUT_CYC    = 5000,
    parameter int CNT_W          = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic            FAULT_CLR,
    input  logic            UP_MAX,
    input  logic            DOWN_MAX,
    input  logic            UP_M,
    input  logic            DOWN_M,
    input  logic            OBSTACLE,
    output logic            ACTIVATE,
    output logic [NREQ-1:0] GRANT,
    output logic            BUSY,
    output logic            FAULT,
    output logic            MOTOR_INHIBIT
);

    localparam int IDX_W = $clog2(NREQ);

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(AUTO_CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MOVE,
        S_MOVING,
        S_OPEN_HOLD,
        S_FAULT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             internal;
    logic [CNT_W-1:0] cnt;

    logic             activate_q;
    logic [NREQ-1:0]  grant_q;
    logic             busy_q;
    logic             fault_q;
    logic             inhibit_q;

    // Arbitration result: first requesting source at or after rr_ptr, wrapping.
    logic             arb_any;
    logic [IDX_W-1:0] arb_idx;
    logic [2*NREQ-1:0] req2;
    logic [NREQ-1:0]  rot;
    logic [IDX_W:0]   arb_sum;

    // "Fully open" needs a consistent limit-switch reading; both limits set at
    // once is a broken sensor state and never counts as open.
    logic door_open;
    assign door_open = UP_MAX & ~DOWN_MAX;

    // Round-robin search over REQ rotated so that rr_ptr sits at bit 0.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        arb_any = 1'b0;
        arb_idx = '0;
        arb_sum = '0;
        req2    = {REQ, REQ};
        rot     = NREQ'(req2 >> rr_ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_any && rot[i]) begin
                arb_any = 1'b1;
                arb_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
                if (arb_sum >= (IDX_W+1)'(NREQ)) begin
                    arb_sum = arb_sum - (IDX_W+1)'(NREQ);
                end
                arb_idx = arb_sum[IDX_W-1:0];
            end
        end
    end

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here sees the values from before this clock edge.
        if (!RST) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            winner     <= '0;
            internal   <= 1'b0;
            cnt        <= '0;
            activate_q <= 1'b0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            inhibit_q  <= 1'b0;
        end else begin
            // ACTIVATE and GRANT are single-cycle pulses unless re-armed below.
            activate_q <= 1'b0;
            grant_q    <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        state      <= S_ISSUE;
                        winner     <= arb_idx;
                        internal   <= 1'b0;
                        activate_q <= 1'b1;
                        grant_q    <= onehot(arb_idx);
                        busy_q     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_MOVE;
                    cnt   <= '0;
                    if (!internal) begin
                        rr_ptr <= next_ptr(winner);
                    end
                end
                S_WAIT_MOVE: begin
                    if (UP_M || DOWN_M) begin
                        state <= S_MOVING;
                        cnt   <= '0;
                    end else if (cnt >= WAIT_LAST) begin
                        // Controller refused the activation: drop it quietly.
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_MOVING: begin
                    if (OBSTACLE && DOWN_M) begin
                        state     <= S_FAULT;
                        busy_q    <= 1'b0;
                        fault_q   <= 1'b1;
                        inhibit_q <= 1'b1;
                    end else if (!UP_M && !DOWN_M) begin
                        if (door_open) begin
                            state <= S_OPEN_HOLD;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (cnt >= TIMEOUT_LAST) begin
                        state     <= S_FAULT;
                        busy_q    <= 1'b0;
                        fault_q   <= 1'b1;
                        inhibit_q <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_OPEN_HOLD: begin
                    if (!door_open) begin
                        // Door was moved by hand; nothing left to auto-close.
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (arb_any) begin
                        state      <= S_ISSUE;
                        winner     <= arb_idx;
                        internal   <= 1'b0;
                        activate_q <= 1'b1;
                        grant_q    <= onehot(arb_idx);
                    end else if (OBSTACLE) begin
                        cnt <= HOLD_LOAD;
                    end else if (cnt == '0) begin
                        state      <= S_ISSUE;
                        internal   <= 1'b1;
                        activate_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_FAULT: begin
                    if (FAULT_CLR) begin
                        state     <= S_IDLE;
                        fault_q   <= 1'b0;
                        inhibit_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy_q    <= 1'b0;
                    fault_q   <= 1'b0;
                    inhibit_q <= 1'b0;
                end
            endcase
        end
    end

    assign ACTIVATE      = activate_q;
    assign GRANT         = grant_q;
    assign BUSY          = busy_q;
    assign FAULT         = fault_q;
    assign MOTOR_INHIBIT = inhibit_q;

endmodule

// File: tb/tb_door_access_sequencer.sv
// Directed bench for door_access_sequencer with short hold/timeout values.
// Outputs are packed as {ACTIVATE, GRANT[2:0], BUSY, FAULT, MOTOR_INHIBIT}.
module tb_door_access_sequencer;

    localparam int NREQ = 3;

    logic            CLK;
    logic            RST;
    logic [NREQ-1:0] REQ;
    logic            FAULT_CLR;
    logic            UP_MAX;
    logic            DOWN_MAX;
    logic            UP_M;
    logic            DOWN_M;
    logic            OBSTACLE;
    logic            ACTIVATE;
    logic [NREQ-1:0] GRANT;
    logic            BUSY;
    logic            FAULT;
    logic            MOTOR_INHIBIT;

    logic [6:0] outs;
    assign outs = {ACTIVATE, GRANT, BUSY, FAULT, MOTOR_INHIBIT};

    int errors = 0;
    int checks = 0;

    door_access_sequencer #(
        .NREQ(NREQ), .AUTO_CLOSE_CYC(8), .TIMEOUT_CYC(20), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .FAULT_CLR(FAULT_CLR),
        .UP_MAX(UP_MAX), .DOWN_MAX(DOWN_MAX), .UP_M(UP_M), .DOWN_M(DOWN_M),
        .OBSTACLE(OBSTACLE), .ACTIVATE(ACTIVATE), .GRANT(GRANT), .BUSY(BUSY),
        .FAULT(FAULT), .MOTOR_INHIBIT(MOTOR_INHIBIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Ticks until ACTIVATE is seen; n = ticks taken, or -1 when the budget runs out.
    task automatic wait_act(input int max, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < max) begin
            tick();
            i++;
            if (ACTIVATE === 1'b1) n = i;
        end
    endtask

    // Act as the door controller: raise the door for n cycles, end fully open.
    task automatic run_up(input int n);
        DOWN_MAX = 1'b0;
        UP_M     = 1'b1;
        tick(n);
        UP_M   = 1'b0;
        UP_MAX = 1'b1;
        tick();
    endtask

    // Respond to an ACTIVATE by closing the door fully.
    task automatic close_door();
        UP_MAX = 1'b0;
        DOWN_M = 1'b1;
        tick(4);
        DOWN_M   = 1'b0;
        DOWN_MAX = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL reset_hold: outs=%b want %b", outs, 7'b0);
        end
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (outs !== 7'b0_000_000) begin
                errors++; $display("FAIL idle_quiet[%0d]: outs=%b want %b", i, outs, 7'b0);
            end
        end
    endtask

    task automatic test_round_robin();
        int n;
        REQ = 3'b101;
        wait_act(10, n);
        checks++;
        if (n !== 1 || outs !== 7'b1_001_100) begin
            errors++; $display("FAIL rr_first: n=%0d outs=%b want n=1 %b", n, outs, 7'b1_001_100);
        end
        wait_act(10, n);
        checks++;
        if (n !== 5 || outs !== 7'b1_100_100) begin
            errors++; $display("FAIL rr_second: n=%0d outs=%b want n=5 %b", n, outs, 7'b1_100_100);
        end
        wait_act(10, n);
        checks++;
        if (n !== 5 || outs !== 7'b1_001_100) begin
            errors++; $display("FAIL rr_wrap: n=%0d outs=%b want n=5 %b", n, outs, 7'b1_001_100);
        end
        REQ = '0;
        tick(4);
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL rr_settle: outs=%b want %b", outs, 7'b0);
        end
    endtask

    task automatic test_auto_close();
        int n;
        REQ = 3'b010;
        tick();
        checks++;
        if (outs !== 7'b1_010_100) begin
            errors++; $display("FAIL ac_grant: outs=%b want %b", outs, 7'b1_010_100);
        end
        REQ = '0;
        run_up(10);
        checks++;
        if (outs !== 7'b0_000_100) begin
            errors++; $display("FAIL ac_hold_entry: outs=%b want %b", outs, 7'b0_000_100);
        end
        wait_act(20, n);
        checks++;
        if (n !== 8 || outs !== 7'b1_000_100) begin
            errors++; $display("FAIL ac_expiry: n=%0d outs=%b want n=8 %b", n, outs, 7'b1_000_100);
        end
        close_door();
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL ac_closed: outs=%b want %b", outs, 7'b0);
        end
    endtask

    task automatic test_obstacle_hold();
        int n;
        REQ = 3'b001;
        tick();
        checks++;
        if (outs !== 7'b1_001_100) begin
            errors++; $display("FAIL oh_grant: outs=%b want %b", outs, 7'b1_001_100);
        end
        REQ = '0;
        run_up(10);
        tick(3);
        OBSTACLE = 1'b1;
        tick(5);
        checks++;
        if (outs !== 7'b0_000_100) begin
            errors++; $display("FAIL oh_blocked: outs=%b want %b", outs, 7'b0_000_100);
        end
        OBSTACLE = 1'b0;
        wait_act(20, n);
        checks++;
        if (n !== 8 || outs !== 7'b1_000_100) begin
            errors++; $display("FAIL oh_reload: n=%0d outs=%b want n=8 %b", n, outs, 7'b1_000_100);
        end
        close_door();
    endtask

    task automatic test_obstacle_fault();
        REQ = 3'b010;
        tick();
        checks++;
        if (outs !== 7'b1_010_100) begin
            errors++; $display("FAIL of_grant: outs=%b want %b", outs, 7'b1_010_100);
        end
        REQ      = '0;
        DOWN_MAX = 1'b0;
        DOWN_M   = 1'b1;
        tick(2);
        OBSTACLE = 1'b1;
        tick();
        checks++;
        if (outs !== 7'b0_000_011) begin
            errors++; $display("FAIL of_fault: outs=%b want %b", outs, 7'b0_000_011);
        end
        DOWN_M   = 1'b0;
        OBSTACLE = 1'b0;
        DOWN_MAX = 1'b1;
        REQ      = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (outs !== 7'b0_000_011) begin
                errors++; $display("FAIL of_ignore_req[%0d]: outs=%b want %b", i, outs, 7'b0_000_011);
            end
        end
        FAULT_CLR = 1'b1;
        tick();
        FAULT_CLR = 1'b0;
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL of_clear: outs=%b want %b", outs, 7'b0);
        end
        tick();
        checks++;
        if (outs !== 7'b1_100_100) begin
            errors++; $display("FAIL of_pending_grant: outs=%b want %b", outs, 7'b1_100_100);
        end
        REQ = '0;
        tick(4);
    endtask

    task automatic test_timeout();
        REQ = 3'b001;
        tick();
        checks++;
        if (outs !== 7'b1_001_100) begin
            errors++; $display("FAIL to_grant: outs=%b want %b", outs, 7'b1_001_100);
        end
        REQ      = '0;
        DOWN_MAX = 1'b0;
        UP_M     = 1'b1;
        tick(2);
        tick(19);
        checks++;
        if (outs !== 7'b0_000_100) begin
            errors++; $display("FAIL to_early: outs=%b want %b", outs, 7'b0_000_100);
        end
        tick();
        checks++;
        if (outs !== 7'b0_000_011) begin
            errors++; $display("FAIL to_fault: outs=%b want %b", outs, 7'b0_000_011);
        end
        UP_M      = 1'b0;
        DOWN_MAX  = 1'b1;
        FAULT_CLR = 1'b1;
        tick();
        FAULT_CLR = 1'b0;
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL to_clear: outs=%b want %b", outs, 7'b0);
        end
    endtask

    task automatic test_no_motor();
        REQ = 3'b010;
        tick();
        checks++;
        if (outs !== 7'b1_010_100) begin
            errors++; $display("FAIL nm_grant: outs=%b want %b", outs, 7'b1_010_100);
        end
        REQ = '0;
        tick(3);
        checks++;
        if (outs !== 7'b0_000_100) begin
            errors++; $display("FAIL nm_waiting: outs=%b want %b", outs, 7'b0_000_100);
        end
        tick();
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL nm_dropped: outs=%b want %b", outs, 7'b0);
        end
    endtask

    task automatic test_fault_clr_ignored();
        FAULT_CLR = 1'b1;
        tick();
        FAULT_CLR = 1'b0;
        tick();
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL clr_in_idle: outs=%b want %b", outs, 7'b0);
        end
    endtask

    task automatic test_reset_mid_move();
        REQ = 3'b010;
        tick();
        checks++;
        if (outs !== 7'b1_010_100) begin
            errors++; $display("FAIL rm_grant: outs=%b want %b", outs, 7'b1_010_100);
        end
        REQ      = '0;
        DOWN_MAX = 1'b0;
        UP_M     = 1'b1;
        tick(4);
        checks++;
        if (outs !== 7'b0_000_100) begin
            errors++; $display("FAIL rm_moving: outs=%b want %b", outs, 7'b0_000_100);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL rm_async: outs=%b want %b", outs, 7'b0);
        end
        tick();
        checks++;
        if (outs !== 7'b0_000_000) begin
            errors++; $display("FAIL rm_held: outs=%b want %b", outs, 7'b0);
        end
        UP_M     = 1'b0;
        DOWN_MAX = 1'b1;
        RST      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs !== 7'b0_000_000) begin
                errors++; $display("FAIL rm_release[%0d]: outs=%b want %b", i, outs, 7'b0);
            end
        end
        REQ = 3'b110;
        tick();
        checks++;
        if (outs !== 7'b1_010_100) begin
            errors++; $display("FAIL rm_ptr_reset: outs=%b want %b", outs, 7'b1_010_100);
        end
        REQ = '0;
        tick(4);
    endtask

    initial begin
        RST       = 1'b0;
        REQ       = '0;
        FAULT_CLR = 1'b0;
        UP_MAX    = 1'b0;
        DOWN_MAX  = 1'b1;
        UP_M      = 1'b0;
        DOWN_M    = 1'b0;
        OBSTACLE  = 1'b0;

        test_reset();
        test_round_robin();
        test_auto_close();
        test_obstacle_hold();
        test_obstacle_fault();
        test_timeout();
        test_no_motor();
        test_fault_clr_ignored();
        test_reset_mid_move();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
